// File: rtl/mau_pkg.sv
// -----------------------------------------------------------------------------
// mau_pkg
// Shared definitions for the memory access unit:
//   - access size codes (SZ_W / SZ_H / SZ_B, plus the reserved code)
//   - response error codes
//   - controller state enum
//   - lane helpers: byte-enable generation, store replication,
//     legality check and size masking of store data
// -----------------------------------------------------------------------------
package mau_pkg;

  localparam logic [1:0] SZ_W = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_B = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_SIZE     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_ERR  = 2'b11
  } mau_state_e;

  // Byte enables for a size at a byte offset within the word (little-endian).
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_W:    be = 4'b1111;
      SZ_H:    be = a[1] ? 4'b1100 : 4'b0011;
      SZ_B:    be = 4'b0001 << a;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data across every lane the size can hit.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      SZ_W:    d = wd;
      SZ_H:    d = {2{wd[15:0]}};
      SZ_B:    d = {4{wd[7:0]}};
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  // Legality check; the reserved size wins over any alignment problem.
  function automatic logic [1:0] check_access(input logic [1:0] size, input logic [1:0] a);
    logic [1:0] code;
    case (size)
      SZ_W:    code = (a != 2'b00) ? ERR_MISALIGN : ERR_NONE;
      SZ_H:    code = a[0] ? ERR_MISALIGN : ERR_NONE;
      SZ_B:    code = ERR_NONE;
      default: code = ERR_SIZE;
    endcase
    return code;
  endfunction

  // Right-justified store data with bits beyond the access size cleared.
  function automatic logic [31:0] size_mask(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      SZ_W:    d = wd;
      SZ_H:    d = {16'h0000, wd[15:0]};
      SZ_B:    d = {24'h00_0000, wd[7:0]};
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mau_if.sv
// -----------------------------------------------------------------------------
// mau_if
// Bundles the CPU request/response handshake and the data-memory bus of the
// memory access unit.
//   modport master : the access unit itself (bus master towards memory,
//                    responder towards the CPU)
//   modport slave  : the environment (CPU MEM stage + data memory)
// Signals: ReqValid/ReqReady/ReqWE/ReqSize/ReqSigned/ReqAddr/ReqWData/ReqPC,
//          RspValid/RspRData/RspErr/RspErrCode,
//          MemReq/MemWE/MemAddr/MemBE/MemWData/MemAck/MemRData
// -----------------------------------------------------------------------------
interface mau_if;

  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWE;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic [31:0] ReqPC;

  logic        RspValid;
  logic [31:0] RspRData;
  logic        RspErr;
  logic [1:0]  RspErrCode;

  logic        MemReq;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [3:0]  MemBE;
  logic [31:0] MemWData;
  logic        MemAck;
  logic [31:0] MemRData;

  modport master (
    input  ReqValid, ReqWE, ReqSize, ReqSigned, ReqAddr, ReqWData, ReqPC,
    input  MemAck, MemRData,
    output ReqReady, RspValid, RspRData, RspErr, RspErrCode,
    output MemReq, MemWE, MemAddr, MemBE, MemWData
  );

  modport slave (
    output ReqValid, ReqWE, ReqSize, ReqSigned, ReqAddr, ReqWData, ReqPC,
    output MemAck, MemRData,
    input  ReqReady, RspValid, RspRData, RspErr, RspErrCode,
    input  MemReq, MemWE, MemAddr, MemBE, MemWData
  );

endinterface

// File: rtl/mau_lane_align.sv
// -----------------------------------------------------------------------------
// mau_lane_align
// Purely combinational lane steering for the memory access unit.
//   i_size, i_addr_lo : access size code and byte offset within the word
//   i_we              : store (1) / load (0); loads drive zero write data
//   i_signed          : load extension mode (1 sign, 0 zero)
//   i_wdata           : right-justified store data
//   i_rdata           : word read from memory
//   o_be              : byte enables
//   o_wdata           : lane-replicated store data
//   o_rdata           : selected load lane(s), extended to 32 bits
// -----------------------------------------------------------------------------
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_we,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];

  // Byte enables, store replication and load extraction/extension.
  always_comb begin
    o_be = lane_be(i_size, i_addr_lo);
    if (i_we) begin
      o_wdata = lane_wdata(i_size, i_wdata);
    end else begin
      o_wdata = 32'h0000_0000;
    end
    case (i_size)
      SZ_W:    o_rdata = i_rdata;
      SZ_H:    o_rdata = {{16{i_signed & w_half[15]}}, w_half};
      SZ_B:    o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
      default: o_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// CPU-side initiator for data memory. Accepts one load/store per handshake,
// checks alignment, runs a req/ack word bus with byte lanes and returns
// extended load data or an error code.
//   Clk      : clock, all state changes on posedge
//   Reset_n  : synchronous active-low reset
//   bus      : mau_if.master (CPU request/response + memory bus)
// Parameter TIMEOUT_CYC : REQ cycles without MemAck before a timeout error
//                         (0 disables the timeout).
// Optional macro MAU_TRACE_EN : prints each completed store
//                         ("@pc: *addr <= data") in the RESP cycle.
// -----------------------------------------------------------------------------
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 32'd255
) (
  input  logic  Clk,
  input  logic  Reset_n,
  mau_if.master bus
);

  // The counter only has to reach TIMEOUT_CYC-1: the limit cycle leaves REQ.
  localparam int unsigned   TW        = (TIMEOUT_CYC > 32'd1) ? $clog2(TIMEOUT_CYC) : 32'd1;
  localparam logic [TW-1:0] TCNT_LAST = (TIMEOUT_CYC == 32'd0) ? {TW{1'b0}} : TW'(TIMEOUT_CYC - 32'd1);

  mau_state_e    r_state;
  mau_state_e    w_next;
  logic          r_req_ready;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_signed;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_pc;
  logic [TW-1:0] r_tcnt;

  logic          r_mem_req;
  logic          r_mem_we;
  logic [31:0]   r_mem_addr;
  logic [3:0]    r_mem_be;
  logic [31:0]   r_mem_wdata;

  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic [1:0]    r_rsp_code;
  logic [31:0]   r_rsp_rdata;

  logic          w_accept;
  logic          w_timeout;
  logic [1:0]    w_chk_code;
  logic [1:0]    w_rsp_code;
  logic          w_in_idle;
  logic [1:0]    w_al_size;
  logic [1:0]    w_al_addr;
  logic          w_al_we;
  logic [3:0]    w_al_be;
  logic [31:0]   w_al_wdata;
  logic [31:0]   w_ld_data;

  assign w_in_idle  = (r_state == ST_IDLE);
  assign w_accept   = w_in_idle && bus.ReqValid;
  assign w_chk_code = check_access(bus.ReqSize, bus.ReqAddr[1:0]);
  assign w_timeout  = (TIMEOUT_CYC != 32'd0) && (r_tcnt == TCNT_LAST);

  // One aligner serves both phases: in IDLE it shapes the incoming request
  // for the bus registers, in REQ it extracts load data using captured fields.
  assign w_al_size = w_in_idle ? bus.ReqSize       : r_size;
  assign w_al_addr = w_in_idle ? bus.ReqAddr[1:0]  : r_addr[1:0];
  assign w_al_we   = w_in_idle ? bus.ReqWE         : r_we;

  mau_lane_align u_align (
    .i_size    (w_al_size),
    .i_addr_lo (w_al_addr),
    .i_we      (w_al_we),
    .i_signed  (r_signed),
    .i_wdata   (bus.ReqWData),
    .i_rdata   (bus.MemRData),
    .o_be      (w_al_be),
    .o_wdata   (w_al_wdata),
    .o_rdata   (w_ld_data)
  );

  // Next-state and response-code selection.
  always_comb begin
    w_next     = r_state;
    w_rsp_code = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (bus.ReqValid) begin
          if (w_chk_code != ERR_NONE) begin
            w_next     = ST_ERR;
            w_rsp_code = w_chk_code;
          end else begin
            w_next     = ST_REQ;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        // An ack arriving in the limit cycle still completes normally.
        if (bus.MemAck) begin
          w_next = ST_RESP;
        end else if (w_timeout) begin
          w_next     = ST_ERR;
          w_rsp_code = ERR_TIMEOUT;
        end else begin
          w_next = ST_REQ;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State, request capture, timeout counter, bus and response registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_we        <= 1'b0;
      r_size      <= SZ_W;
      r_signed    <= 1'b0;
      r_addr      <= 32'h0000_0000;
      r_wdata     <= 32'h0000_0000;
      r_pc        <= 32'h0000_0000;
      r_tcnt      <= {TW{1'b0}};
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= 32'h0000_0000;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_code  <= ERR_NONE;
      r_rsp_rdata <= 32'h0000_0000;
    end else begin
      r_state     <= w_next;
      r_req_ready <= (w_next == ST_IDLE);

      if (w_accept) begin
        r_we     <= bus.ReqWE;
        r_size   <= bus.ReqSize;
        r_signed <= bus.ReqSigned;
        r_addr   <= bus.ReqAddr;
        r_wdata  <= bus.ReqWData;
        r_pc     <= bus.ReqPC;
      end

      // Zero outside REQ, so every REQ entry starts counting from zero.
      if (r_state == ST_REQ) begin
        r_tcnt <= r_tcnt + TW'(1);
      end else begin
        r_tcnt <= {TW{1'b0}};
      end

      // Bus outputs load on a legal accept, hold through REQ, clear on exit.
      if (w_accept && (w_next == ST_REQ)) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= bus.ReqWE;
        r_mem_addr  <= {bus.ReqAddr[31:2], 2'b00};
        r_mem_be    <= w_al_be;
        r_mem_wdata <= w_al_wdata;
      end else if (w_next != ST_REQ) begin
        r_mem_req   <= 1'b0;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= 32'h0000_0000;
        r_mem_be    <= 4'b0000;
        r_mem_wdata <= 32'h0000_0000;
      end

      r_rsp_valid <= (w_next == ST_RESP) || (w_next == ST_ERR);
      r_rsp_err   <= (w_next == ST_ERR);
      r_rsp_code  <= w_rsp_code;
      if ((r_state == ST_REQ) && bus.MemAck && !r_we) begin
        r_rsp_rdata <= w_ld_data;
      end else begin
        r_rsp_rdata <= 32'h0000_0000;
      end
    end
  end

`ifdef MAU_TRACE_EN
  // Store trace in the response cycle of each successful store.
  always_ff @(posedge Clk) begin
    if (Reset_n && (r_state == ST_RESP) && r_we) begin
      $display("@%h: *%h <= %h", r_pc, r_addr, size_mask(r_size, r_wdata));
    end
  end
`else
  // PC, full address and raw store data only feed the trace.
  logic w_unused_trace;
  assign w_unused_trace = ^{r_pc, r_wdata, r_addr[31:2]};
`endif

  assign bus.ReqReady   = r_req_ready;
  assign bus.RspValid   = r_rsp_valid;
  assign bus.RspRData   = r_rsp_rdata;
  assign bus.RspErr     = r_rsp_err;
  assign bus.RspErrCode = r_rsp_code;
  assign bus.MemReq     = r_mem_req;
  assign bus.MemWE      = r_mem_we;
  assign bus.MemAddr    = r_mem_addr;
  assign bus.MemBE      = r_mem_be;
  assign bus.MemWData   = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYC = 4).
// Latencies are counted with the accept cycle as cycle 1.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  mau_if u_if ();

  mem_access_unit #(.TIMEOUT_CYC(32'd4)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (u_if)
  );

  always #5 clk = ~clk;

  // Observations collected by xact
  logic        o_ready_ok;
  logic        o_ready_in_req;
  logic        o_req_seen;
  logic        o_we;
  logic [31:0] o_addr;
  logic [3:0]  o_be;
  logic [31:0] o_wdata;
  logic        o_stable;
  int          o_req_cycles;
  int          o_lat;
  logic        o_err;
  logic [1:0]  o_code;
  logic [31:0] o_rdata;
  logic        o_req_at_rsp;
  logic        o_pulse_after;

  // Drives one request, acks on REQ cycle ack_at (0 = never), records outputs.
  task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rd, input int ack_at);
    int guard;
    guard = 0;
    while (u_if.ReqReady !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    o_ready_ok     = (u_if.ReqReady === 1'b1);
    u_if.ReqWE     = we;
    u_if.ReqSize   = size;
    u_if.ReqSigned = sgn;
    u_if.ReqAddr   = addr;
    u_if.ReqWData  = wd;
    u_if.ReqPC     = 32'h0000_4000 + addr;
    u_if.MemRData  = rd;
    u_if.ReqValid  = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs: the unit must work from its captured copy.
    u_if.ReqValid  = 1'b0;
    u_if.ReqAddr   = 32'hDEAD_BEEF;
    u_if.ReqSize   = 2'b11;
    u_if.ReqWData  = 32'h5A5A_5A5A;
    u_if.ReqWE     = ~we;
    u_if.ReqSigned = ~sgn;
    o_ready_in_req = u_if.ReqReady;
    o_req_seen     = u_if.MemReq;
    o_we           = u_if.MemWE;
    o_addr         = u_if.MemAddr;
    o_be           = u_if.MemBE;
    o_wdata        = u_if.MemWData;
    o_stable       = 1'b1;
    o_req_cycles   = 0;
    o_lat          = 0;
    o_err          = 1'b0;
    o_code         = 2'b00;
    o_rdata        = 32'h0;
    o_req_at_rsp   = 1'b0;
    o_pulse_after  = 1'b0;
    for (int n = 2; n <= 20; n++) begin
      if (u_if.RspValid === 1'b1) begin
        o_lat        = n;
        o_err        = u_if.RspErr;
        o_code       = u_if.RspErrCode;
        o_rdata      = u_if.RspRData;
        o_req_at_rsp = u_if.MemReq;
        break;
      end
      if (u_if.MemReq === 1'b1) begin
        o_req_cycles++;
        if (u_if.MemWE !== o_we || u_if.MemAddr !== o_addr ||
            u_if.MemBE !== o_be || u_if.MemWData !== o_wdata) o_stable = 1'b0;
        if (o_req_cycles == ack_at) u_if.MemAck = 1'b1;
      end
      @(posedge clk); #1;
      u_if.MemAck = 1'b0;
    end
    if (o_lat != 0) begin
      @(posedge clk); #1;
      o_pulse_after = u_if.RspValid;
    end
  endtask

  task automatic test_reset();
    u_if.ReqValid = 1'b0; u_if.ReqWE = 1'b0; u_if.ReqSize = 2'b00; u_if.ReqSigned = 1'b0;
    u_if.ReqAddr = 32'h0; u_if.ReqWData = 32'h0; u_if.ReqPC = 32'h0;
    u_if.MemAck = 1'b0; u_if.MemRData = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (u_if.ReqReady !== 1'b1) begin
      tests_failed++; $display("FAIL reset_ready: got %b want 1", u_if.ReqReady);
    end
    tests_run++;
    if ({u_if.MemReq, u_if.MemWE, u_if.MemAddr, u_if.MemBE, u_if.MemWData} !== 70'h0) begin
      tests_failed++; $display("FAIL reset_bus: req=%b we=%b addr=%h be=%b wd=%h want all 0",
        u_if.MemReq, u_if.MemWE, u_if.MemAddr, u_if.MemBE, u_if.MemWData);
    end
    tests_run++;
    if ({u_if.RspValid, u_if.RspErr, u_if.RspErrCode, u_if.RspRData} !== 36'h0) begin
      tests_failed++; $display("FAIL reset_rsp: v=%b e=%b c=%b d=%h want all 0",
        u_if.RspValid, u_if.RspErr, u_if.RspErrCode, u_if.RspRData);
    end
  endtask

  task automatic test_store_word();
    xact(1'b1, 2'b00, 1'b0, 32'h0000_0100, 32'h1234_5678, 32'h0, 1);
    tests_run++;
    if ({o_ready_ok, o_ready_in_req, o_req_seen, o_we} !== 4'b1011) begin
      tests_failed++; $display("FAIL sw_hs: rdy=%b rdy_req=%b req=%b we=%b want 1 0 1 1",
        o_ready_ok, o_ready_in_req, o_req_seen, o_we);
    end
    tests_run++;
    if ({o_addr, o_be, o_wdata} !== {32'h0000_0100, 4'b1111, 32'h1234_5678}) begin
      tests_failed++; $display("FAIL sw_bus: addr=%h be=%b wd=%h want 00000100 1111 12345678",
        o_addr, o_be, o_wdata);
    end
    tests_run++;
    if (o_lat != 3 || o_err !== 1'b0 || o_code !== 2'b00 || o_rdata !== 32'h0 ||
        o_req_at_rsp !== 1'b0 || o_pulse_after !== 1'b0 || o_stable !== 1'b1) begin
      tests_failed++; $display("FAIL sw_rsp: lat=%0d err=%b code=%b d=%h req=%b pulse=%b stab=%b want 3 0 00 0 0 0 1",
        o_lat, o_err, o_code, o_rdata, o_req_at_rsp, o_pulse_after, o_stable);
    end
  endtask

  task automatic test_byte();
    xact(1'b1, 2'b10, 1'b0, 32'h0000_0103, 32'h0000_00AB, 32'h0, 1);
    tests_run++;
    if ({o_addr, o_be, o_wdata} !== {32'h0000_0100, 4'b1000, 32'hABAB_ABAB}) begin
      tests_failed++; $display("FAIL sb_bus: addr=%h be=%b wd=%h want 00000100 1000 abababab",
        o_addr, o_be, o_wdata);
    end
    xact(1'b0, 2'b10, 1'b1, 32'h0000_0103, 32'h0, 32'h8000_0000, 1);
    tests_run++;
    if ({o_we, o_be, o_wdata, o_rdata} !== {1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80} || o_lat != 3) begin
      tests_failed++; $display("FAIL lb: we=%b be=%b wd=%h d=%h lat=%0d want 0 1000 0 ffffff80 3",
        o_we, o_be, o_wdata, o_rdata, o_lat);
    end
    xact(1'b0, 2'b10, 1'b0, 32'h0000_0103, 32'h0, 32'h8000_0000, 1);
    tests_run++;
    if (o_rdata !== 32'h0000_0080) begin
      tests_failed++; $display("FAIL lbu: d=%h want 00000080", o_rdata);
    end
  endtask

  task automatic test_half();
    xact(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'h8001_1234, 1);
    tests_run++;
    if ({o_be, o_rdata} !== {4'b1100, 32'hFFFF_8001}) begin
      tests_failed++; $display("FAIL lh: be=%b d=%h want 1100 ffff8001", o_be, o_rdata);
    end
    xact(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 32'h8001_1234, 1);
    tests_run++;
    if (o_rdata !== 32'h0000_8001) begin
      tests_failed++; $display("FAIL lhu: d=%h want 00008001", o_rdata);
    end
    xact(1'b1, 2'b01, 1'b0, 32'h0000_0200, 32'h1234_BEEF, 32'h0, 1);
    tests_run++;
    if ({o_addr, o_be, o_wdata} !== {32'h0000_0200, 4'b0011, 32'hBEEF_BEEF}) begin
      tests_failed++; $display("FAIL sh: addr=%h be=%b wd=%h want 00000200 0011 beefbeef",
        o_addr, o_be, o_wdata);
    end
  endtask

  task automatic test_errors();
    xact(1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0, 32'hFFFF_FFFF, 1);
    tests_run++;
    if ({o_req_seen, o_err, o_code, o_rdata} !== {1'b0, 1'b1, 2'b01, 32'h0} || o_lat != 2) begin
      tests_failed++; $display("FAIL lw_misalign: req=%b err=%b code=%b d=%h lat=%0d want 0 1 01 0 2",
        o_req_seen, o_err, o_code, o_rdata, o_lat);
    end
    xact(1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h1, 32'h0, 1);
    tests_run++;
    if ({o_req_seen, o_err, o_code} !== {1'b0, 1'b1, 2'b01}) begin
      tests_failed++; $display("FAIL sh_misalign: req=%b err=%b code=%b want 0 1 01",
        o_req_seen, o_err, o_code);
    end
    xact(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 1);
    tests_run++;
    if ({o_req_seen, o_err, o_code} !== {1'b0, 1'b1, 2'b11} || o_lat != 2) begin
      tests_failed++; $display("FAIL size_11: req=%b err=%b code=%b lat=%0d want 0 1 11 2",
        o_req_seen, o_err, o_code, o_lat);
    end
  endtask

  task automatic test_timeout();
    xact(1'b0, 2'b00, 1'b0, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 0);
    tests_run++;
    if ({o_err, o_code, o_rdata, o_req_at_rsp} !== {1'b1, 2'b10, 32'h0, 1'b0} ||
        o_req_cycles != 4 || o_lat != 6) begin
      tests_failed++; $display("FAIL timeout: err=%b code=%b d=%h req=%b cyc=%0d lat=%0d want 1 10 0 0 4 6",
        o_err, o_code, o_rdata, o_req_at_rsp, o_req_cycles, o_lat);
    end
    xact(1'b0, 2'b00, 1'b0, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 4);
    tests_run++;
    if ({o_err, o_code, o_rdata} !== {1'b0, 2'b00, 32'hCAFE_F00D} ||
        o_req_cycles != 4 || o_lat != 6 || o_stable !== 1'b1) begin
      tests_failed++; $display("FAIL ack_at_limit: err=%b code=%b d=%h cyc=%0d lat=%0d stab=%b want 0 00 cafef00d 4 6 1",
        o_err, o_code, o_rdata, o_req_cycles, o_lat, o_stable);
    end
  endtask

  task automatic test_back_to_back();
    xact(1'b1, 2'b10, 1'b0, 32'h0000_0101, 32'h0000_0011, 32'h0, 2);
    tests_run++;
    if ({o_addr, o_be, o_wdata} !== {32'h0000_0100, 4'b0010, 32'h1111_1111} || o_lat != 4) begin
      tests_failed++; $display("FAIL b2b_1: addr=%h be=%b wd=%h lat=%0d want 00000100 0010 11111111 4",
        o_addr, o_be, o_wdata, o_lat);
    end
    xact(1'b1, 2'b01, 1'b0, 32'h0000_0106, 32'h0000_2233, 32'h0, 1);
    tests_run++;
    if ({o_ready_ok, o_addr, o_be, o_wdata} !== {1'b1, 32'h0000_0104, 4'b1100, 32'h2233_2233}) begin
      tests_failed++; $display("FAIL b2b_2: rdy=%b addr=%h be=%b wd=%h want 1 00000104 1100 22332233",
        o_ready_ok, o_addr, o_be, o_wdata);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_rsp;
    saw_rsp = 1'b0;
    // Stray ack while idle must not produce a response.
    u_if.MemAck = 1'b1;
    @(posedge clk); #1;
    u_if.MemAck = 1'b0;
    tests_run++;
    if (u_if.RspValid !== 1'b0 || u_if.MemReq !== 1'b0) begin
      tests_failed++; $display("FAIL idle_ack: rv=%b req=%b want 0 0", u_if.RspValid, u_if.MemReq);
    end
    u_if.ReqWE = 1'b0; u_if.ReqSize = 2'b00; u_if.ReqAddr = 32'h0000_0100; u_if.ReqValid = 1'b1;
    @(posedge clk); #1;
    u_if.ReqValid = 1'b0;
    tests_run++;
    if (u_if.MemReq !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_pre: req=%b want 1", u_if.MemReq);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (u_if.MemReq !== 1'b0 || u_if.RspValid !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_drop: req=%b rv=%b want 0 0", u_if.MemReq, u_if.RspValid);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (u_if.RspValid === 1'b1) saw_rsp = 1'b1;
    end
    tests_run++;
    if (saw_rsp !== 1'b0 || u_if.ReqReady !== 1'b1 || u_if.MemReq !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_after: rsp_seen=%b rdy=%b req=%b want 0 1 0",
        saw_rsp, u_if.ReqReady, u_if.MemReq);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_byte();
    test_half();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
